// File: rtl/score_entry_pkg.sv
// Shared definitions for the score entry block: ASCII codes, state encoding
// and the width helper used to size the score value.
`timescale 1ns/1ps
package score_entry_pkg;

    localparam logic [6:0] ASCII_ZERO  = 7'd48;
    localparam logic [6:0] ASCII_NINE  = 7'd57;
    localparam logic [6:0] ASCII_BS    = 7'd8;
    localparam logic [6:0] ASCII_ENTER = 7'd13;

    // Wide enough for four decimal digits (9999).
    localparam int ACC_BITS = 14;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CONVERT,
        ST_DONE
    } state_t;

    // Bits needed to hold 0..n-1.
    function automatic int logb2(input int n);
        int bits;
        int v;
        bits = 0;
        v    = n - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/score_entry_mul10_add.sv
// Combinational acc*10 + digit step of the decimal-to-binary conversion,
// built from shifts and adds so no multiplier is inferred.
`timescale 1ns/1ps
module mul10_add
    import score_entry_pkg::*;
(
    input  logic [ACC_BITS-1:0] i_acc,
    input  logic [3:0]          i_digit,
    output logic [ACC_BITS-1:0] o_sum
);

    assign o_sum = (i_acc << 3) + (i_acc << 1) + {{(ACC_BITS-4){1'b0}}, i_digit};

endmodule

// File: rtl/score_entry.sv
// Buffers typed decimal digits for echo and, on Enter, converts them MSD-first
// into a saturated binary score with a one-cycle valid pulse.
`timescale 1ns/1ps
module score_entry
    import score_entry_pkg::*;
#(
    parameter int H          = 32,
    parameter int V          = 32,
    parameter int MAX_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_char_valid,
    input  logic [6:0]                    i_char,
    output logic                          o_ready,
    output logic [4*MAX_DIGITS-1:0]       o_digits,
    output logic [2:0]                    o_digit_count,
    output logic [logb2(H*V)-1:0]         o_value,
    output logic                          o_value_valid,
    output logic                          o_saturated
);

    localparam int                    SCORE_BITS = logb2(H*V);
    localparam int                    IDX_BITS   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam logic [ACC_BITS-1:0]   SCORE_MAX  = ACC_BITS'(H*V - 1);
    localparam logic [IDX_BITS-1:0]   IDX_LAST   = IDX_BITS'(MAX_DIGITS - 1);
    localparam logic [2:0]            COUNT_MAX  = 3'(MAX_DIGITS);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [4*MAX_DIGITS-1:0] r_digits;
    logic [2:0]              r_count;
    logic [ACC_BITS-1:0]     r_acc;
    logic [IDX_BITS-1:0]     r_idx;
    logic [SCORE_BITS-1:0]   r_value;
    logic                    r_saturated;

    logic                    w_accept;
    logic                    w_is_digit;
    logic [3:0]              w_digit;
    logic [3:0]              w_cur_digit;
    logic [ACC_BITS-1:0]     w_acc_next;
    logic                    w_last_digit;

    assign o_ready       = (r_state == ST_ENTRY);
    assign o_value_valid = (r_state == ST_DONE);
    assign o_digits      = r_digits;
    assign o_digit_count = r_count;
    assign o_value       = r_value;
    assign o_saturated   = r_saturated;

    assign w_accept     = i_char_valid && o_ready;
    assign w_is_digit   = (i_char >= ASCII_ZERO) && (i_char <= ASCII_NINE);
    assign w_digit      = 4'(i_char - ASCII_ZERO);
    assign w_cur_digit  = r_digits[4*r_idx +: 4];
    assign w_last_digit = (r_idx == '0);

    mul10_add u_mul10_add (
        .i_acc   (r_acc),
        .i_digit (w_cur_digit),
        .o_sum   (w_acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ENTRY;
        else        r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_ENTRY:   if (w_accept && (i_char == ASCII_ENTER)) w_next_state = ST_CONVERT;
            ST_CONVERT: if (w_last_digit)                         w_next_state = ST_DONE;
            ST_DONE:    w_next_state = ST_ENTRY;
            default:    w_next_state = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits    <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_value     <= '0;
            r_saturated <= 1'b0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (w_accept) begin
                        if (w_is_digit) begin
                            if (r_count < COUNT_MAX) begin
                                r_digits <= {r_digits[4*MAX_DIGITS-5:0], w_digit};
                                r_count  <= r_count + 3'd1;
                            end
                        end else if (i_char == ASCII_BS) begin
                            if (r_count != 3'd0) begin
                                r_digits <= r_digits >> 4;
                                r_count  <= r_count - 3'd1;
                            end
                        end else if (i_char == ASCII_ENTER) begin
                            r_acc <= '0;
                            r_idx <= IDX_LAST;
                        end
                    end
                end
                ST_CONVERT: begin
                    r_acc <= w_acc_next;
                    if (w_last_digit) begin
                        // Clamp to the top of the grid-derived score range.
                        if (w_acc_next > SCORE_MAX) begin
                            r_value     <= SCORE_MAX[SCORE_BITS-1:0];
                            r_saturated <= 1'b1;
                        end else begin
                            r_value     <= w_acc_next[SCORE_BITS-1:0];
                            r_saturated <= 1'b0;
                        end
                    end else begin
                        r_idx <= r_idx - IDX_BITS'(1);
                    end
                end
                ST_DONE: begin
                    r_digits <= '0;
                    r_count  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_entry.sv
// Randomized self-checking bench for score_entry against a queue-based
// decimal model of the digit buffer and conversion.
`timescale 1ns/1ps
module tb_score_entry;

    localparam int SCORE_MAX = 32*32 - 1;

    logic        clk;
    logic        rst_n;
    logic        i_char_valid;
    logic [6:0]  i_char;
    logic        o_ready;
    logic [15:0] o_digits;
    logic [2:0]  o_digit_count;
    logic [9:0]  o_value;
    logic        o_value_valid;
    logic        o_saturated;

    int checks = 0;
    int errors = 0;

    int m_q[$];
    int m_value = 0;
    int m_sat   = 0;

    score_entry dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_char_valid  (i_char_valid),
        .i_char        (i_char),
        .o_ready       (o_ready),
        .o_digits      (o_digits),
        .o_digit_count (o_digit_count),
        .o_value       (o_value),
        .o_value_valid (o_value_valid),
        .o_saturated   (o_saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_digits();
        logic [15:0] r;
        r = '0;
        foreach (m_q[i]) r = {r[11:0], 4'(m_q[i])};
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_count"},  32'(o_digit_count), m_q.size());
        check({tag, "_digits"}, 32'(o_digits),      32'(exp_digits()));
        check({tag, "_value"},  32'(o_value),       m_value);
        check({tag, "_sat"},    32'(o_saturated),   m_sat);
        check({tag, "_valid"},  32'(o_value_valid), 0);
        check({tag, "_ready"},  32'(o_ready),       1);
    endtask

    // Presents one char for one edge, updates the model and checks the result.
    // On Enter it also holds a '5' on the input through the busy period.
    task automatic send_char(input logic [6:0] c);
        int v;
        int cycles;
        @(negedge clk);
        i_char_valid = 1'b1;
        i_char       = c;
        @(posedge clk);
        #1;
        i_char_valid = 1'b0;
        if (c == 7'd13) begin
            v = 0;
            foreach (m_q[i]) v = v * 10 + m_q[i];
            m_sat   = (v > SCORE_MAX) ? 1 : 0;
            m_value = m_sat ? SCORE_MAX : v;
            check("busy_ready", 32'(o_ready), 0);
            i_char_valid = 1'b1;
            i_char       = 7'd53;
            cycles = 0;
            while (!o_value_valid && cycles < 10) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            i_char_valid = 1'b0;
            check("latency", cycles, 4);
            check("conv_value", 32'(o_value), m_value);
            check("conv_sat", 32'(o_saturated), m_sat);
            check("conv_ready", 32'(o_ready), 0);
            @(posedge clk);
            #1;
            m_q.delete();
            check_idle("after_done");
        end else begin
            if (c >= 7'd48 && c <= 7'd57) begin
                if (m_q.size() < 4) m_q.push_back(int'(c) - 48);
            end else if (c == 7'd8) begin
                if (m_q.size() > 0) void'(m_q.pop_back());
            end
            check_idle("entry");
        end
    endtask

    initial begin
        int r;
        logic [6:0] c;
        rst_n        = 1'b0;
        i_char_valid = 1'b0;
        i_char       = '0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 123
        send_char(7'd49); send_char(7'd50); send_char(7'd51);
        check("d123_digits", 32'(o_digits), 32'h0123);
        send_char(7'd13);

        // five nines: fifth ignored, saturates
        repeat (5) send_char(7'd57);
        check("d9999_count", 32'(o_digit_count), 4);
        send_char(7'd13);
        check("d9999_sat", 32'(o_saturated), 1);

        // 4 5 BS 7 -> 47, then backspace on empty buffer and a non-digit
        send_char(7'd52); send_char(7'd53); send_char(7'd8); send_char(7'd55);
        check("d47_digits", 32'(o_digits), 32'h0047);
        send_char(7'd13);
        send_char(7'd8);
        send_char(7'd65);

        // empty Enter
        send_char(7'd13);
        check("empty_value", 32'(o_value), 0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      c = 7'(48 + $urandom_range(0, 9));
            else if (r < 75) c = 7'd8;
            else if (r < 85) c = 7'd13;
            else             c = 7'($urandom_range(0, 127));
            send_char(c);
        end

        // leave a nonzero value, then reset during the second CONVERT cycle
        send_char(7'd56); send_char(7'd49); send_char(7'd13);
        send_char(7'd50); send_char(7'd51);
        @(negedge clk);
        i_char_valid = 1'b1;
        i_char       = 7'd13;
        @(posedge clk);
        #1;
        i_char_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_q.delete();
        m_value = 0;
        m_sat   = 0;
        check_idle("abort");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_valid", 32'(o_value_valid), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("post_abort_valid", 32'(o_value_valid), 0);
        end
        send_char(7'd49); send_char(7'd50); send_char(7'd51);
        send_char(7'd13);
        check("post_abort_value", 32'(o_value), 123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
